spike_rate_decoder: RTL

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

---
 rtl/spike_rate_decoder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/spike_rate_decoder.sv
`default_nettype none
// ============================================================================
// Module      : spike_rate_decoder
// Description : Counts spike edges per 2^WINDOW_LOG2-cycle window and, when
//               SPIKE_DECODER_ISI_EN is defined, measures the inter-spike interval.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_rate_decoder #(
    parameter int WINDOW_LOG2 = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       spike,
    output logic [7:0] rate,
    output logic       rate_valid,
    output logic [7:0] isi,
    output logic       isi_valid
);

    localparam logic [0:0]             c_IDLE     = 1'b0;
    localparam logic [0:0]             c_RUN      = 1'b1;
    localparam logic [WINDOW_LOG2-1:0] c_WIN_LAST = '1;
    localparam logic [7:0]             c_SAT      = 8'hFF;

    logic [0:0]             r_state;
    logic [0:0]             w_state_next;
    logic                   w_run;
    logic                   r_spike_q;
    logic                   w_edge;
    logic [WINDOW_LOG2-1:0] r_win_cnt;
    logic [7:0]             r_spk_cnt;
    logic [8:0]             w_spk_sum;
    logic                   w_win_last;
    logic [7:0]             r_rate;
    logic                   r_rate_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_spike_q <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_spike_q <= spike;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (en)  w_state_next = c_RUN;
            c_RUN:   if (!en) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // The transition takes effect in the cycle it is evaluated, so an edge
    // on the first enabled cycle after reset is already counted.
    always_comb begin
        w_run = 1'b0;
        case (w_state_next)
            c_RUN:   w_run = 1'b1;
            default: w_run = 1'b0;
        endcase
    end

    assign w_edge     = spike & ~r_spike_q;
    assign w_spk_sum  = {1'b0, r_spk_cnt} + {8'd0, w_edge};
    assign w_win_last = (r_win_cnt == c_WIN_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_cnt    <= '0;
            r_spk_cnt    <= '0;
            r_rate       <= '0;
            r_rate_valid <= 1'b0;
        end else if (!w_run) begin
            r_win_cnt    <= '0;
            r_spk_cnt    <= '0;
            r_rate_valid <= 1'b0;
        end else begin
            r_win_cnt    <= r_win_cnt + 1'b1;
            r_rate_valid <= w_win_last;
            if (w_win_last) begin
                r_rate    <= w_spk_sum[8] ? c_SAT : w_spk_sum[7:0];
                r_spk_cnt <= '0;
            end else if (w_edge && (r_spk_cnt != c_SAT)) begin
                r_spk_cnt <= r_spk_cnt + 8'd1;
            end
        end
    end

    assign rate       = r_rate;
    assign rate_valid = r_rate_valid;

`ifdef SPIKE_DECODER_ISI_EN
    logic [7:0] r_isi_cnt;
    logic       r_armed;
    logic [7:0] r_isi;
    logic       r_isi_valid;

    // The counter holds the distance to the previous edge, so loading 1 on an
    // edge makes it read d when the next edge arrives d cycles later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_isi_cnt   <= '0;
            r_armed     <= 1'b0;
            r_isi       <= '0;
            r_isi_valid <= 1'b0;
        end else if (!w_run) begin
            r_isi_cnt   <= '0;
            r_armed     <= 1'b0;
            r_isi_valid <= 1'b0;
        end else begin
            r_isi_valid <= w_edge & r_armed;
            if (w_edge) begin
                if (r_armed) r_isi <= r_isi_cnt;
                r_isi_cnt <= 8'd1;
                r_armed   <= 1'b1;
            end else if (r_armed && (r_isi_cnt != c_SAT)) begin
                r_isi_cnt <= r_isi_cnt + 8'd1;
            end
        end
    end

    assign isi       = r_isi;
    assign isi_valid = r_isi_valid;
`else
    assign isi       = '0;
    assign isi_valid = 1'b0;
`endif

endmodule
`default_nettype wire
